// File: rtl/alu_seq_param_pkg.sv
// rtl/alu_seq_param_pkg.sv - shared opcode, flag and state definitions for the sequential ALU
// Package alu_pkg: opcode map, {N,Z,C,V} flag bit positions, FSM state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_INC  = 4'h3,
    OP_DEC  = 4'h4,
    OP_NOTA = 4'h5,
    OP_NOTB = 4'h6,
    OP_RSUB = 4'h7,
    OP_OR   = 4'h8,
    OP_NOR  = 4'h9,
    OP_XOR  = 4'hA,
    OP_XNOR = 4'hB,
    OP_AND  = 4'hC,
    OP_NAND = 4'hD,
    OP_SHL  = 4'hE,
    OP_SHR  = 4'hF
  } opcode_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_param_if.sv
// rtl/alu_seq_param_if.sv - operation/result handshake bundle for the sequential ALU
// Request side: in_valid/in_ready, a, b, opcode. Response side: out_valid/out_ready,
// result, flags. master = requester/consumer, slave = ALU.
interface alu_seq_param_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
// Ports: clk, rst_n (async, active-low), start (load a/b), a, b, done (one-cycle pulse
// after the last bit), product (full 2*WIDTH result, held until the next start).
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Bit 0 is consumed in the start cycle itself, so bits 1..WIDTH-1 follow on
  // the next WIDTH-1 cycles and all WIDTH bits take exactly WIDTH cycles.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = b >> 1;
      cnt_d    = CW'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH-1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - parametrised sequential ALU with valid/ready handshake
// Ports: clk, rst_n (async, active-low), bus (alu_seq_param_if.slave): operation in via
// in_valid/in_ready/a/b/opcode, result out via out_valid/out_ready/result/flags {N,Z,C,V}.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_param_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;

  opcode_e            op;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   arith_x, arith_y;
  logic [WIDTH:0]     sum_ext, dif_ext;
  logic               add_v, sub_v, shift_big;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  assign op     = opcode_e'(bus.opcode);
  assign accept = bus.in_valid && in_ready_q;

  // One adder and one subtractor serve add/inc and sub/dec/rsub.
  always_comb begin
    arith_x = bus.a;
    arith_y = bus.b;
    case (op)
      OP_INC, OP_DEC: arith_y = WIDTH'(1);
      OP_RSUB: begin
        arith_x = bus.b;
        arith_y = bus.a;
      end
      default: ;
    endcase
  end

  // The extra top bit of dif_ext is the borrow (x < y unsigned).
  assign sum_ext   = {1'b0, arith_x} + {1'b0, arith_y};
  assign dif_ext   = {1'b0, arith_x} - {1'b0, arith_y};
  assign add_v     = (arith_x[MSB] == arith_y[MSB]) && (sum_ext[MSB] != arith_x[MSB]);
  assign sub_v     = (arith_x[MSB] != arith_y[MSB]) && (dif_ext[MSB] != arith_x[MSB]);
  // Any b of WIDTH or more shifts everything out, regardless of its low bits.
  assign shift_big = (bus.b > WIDTH'(MSB));

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = add_v;
      end
      OP_SUB, OP_DEC, OP_RSUB: begin
        alu_res = dif_ext[MSB:0];
        alu_c   = dif_ext[WIDTH];
        alu_v   = sub_v;
      end
      OP_NOTA: alu_res = ~bus.a;
      OP_NOTB: alu_res = ~bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_XNOR: alu_res = ~(bus.a ^ bus.b);
      OP_AND:  alu_res = bus.a & bus.b;
      OP_NAND: alu_res = ~(bus.a & bus.b);
      OP_SHL:  alu_res = shift_big ? '0 : (bus.a << bus.b[SHW-1:0]);
      OP_SHR:  alu_res = shift_big ? '0 : (bus.a >> bus.b[SHW-1:0]);
      default: alu_res = '0;
    endcase
  end

  // Single-cycle ops are computed from the live inputs and latched at acceptance;
  // multiply operands are latched inside the multiplier on the same edge.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = alu_res;
            flags_d     = pack_flags(alu_res[MSB], alu_res == '0, alu_c, alu_v);
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = mul_product[MSB:0];
          flags_d     = pack_flags(mul_product[MSB], mul_product[MSB:0] == '0,
                                   |mul_product[2*WIDTH-1:WIDTH], 1'b0);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Registered from the next state so in_ready stays low during reset and
  // rises on the first edge after release.
  assign in_ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - directed self-checking bench for alu_seq_param at WIDTH 8/16/32
module tb_alu_seq_param;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_seq_param_if #(.WIDTH(8))  if8  ();
  alu_seq_param_if #(.WIDTH(16)) if16 ();
  alu_seq_param_if #(.WIDTH(32)) if32 ();

  alu_seq_param #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  alu_seq_param #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  alu_seq_param #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [63:0] a,
                       input logic [63:0] b, input logic [3:0] op);
    case (w)
      8:  begin if8.in_valid  = v; if8.a  = a[7:0];  if8.b  = b[7:0];  if8.opcode  = op; end
      16: begin if16.in_valid = v; if16.a = a[15:0]; if16.b = b[15:0]; if16.opcode = op; end
      default: begin if32.in_valid = v; if32.a = a[31:0]; if32.b = b[31:0]; if32.opcode = op; end
    endcase
  endtask

  task automatic set_ordy(input int w, input logic r);
    case (w)
      8:  if8.out_ready  = r;
      16: if16.out_ready = r;
      default: if32.out_ready = r;
    endcase
  endtask

  task automatic sample(input int w, output logic ov, output logic ir,
                        output logic [63:0] res, output logic [3:0] fl);
    case (w)
      8:  begin ov = if8.out_valid;  ir = if8.in_ready;  res = 64'(if8.result);  fl = if8.flags;  end
      16: begin ov = if16.out_valid; ir = if16.in_ready; res = 64'(if16.result); fl = if16.flags; end
      default: begin ov = if32.out_valid; ir = if32.in_ready; res = 64'(if32.result); fl = if32.flags; end
    endcase
  endtask

  // Entered and left #1 after a rising edge with the ALU idle and out_ready high.
  task automatic run_op(input int w, input string tag, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] op, input int exp_lat,
                        input logic [63:0] exp_res, input logic [3:0] exp_fl);
    int lat;
    logic ov, ir, ir_any;
    logic [63:0] r;
    logic [3:0] f;
    drive(w, 1'b1, a, b, op);
    @(posedge clk); #1;
    drive(w, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 64'h1234_5678_9ABC_DEF0, 4'h0);
    lat = 1;
    sample(w, ov, ir, r, f);
    ir_any = ir;
    while (!ov && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      sample(w, ov, ir, r, f);
      ir_any = ir_any | ir;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, r, exp_res);
    chk({tag, " flags"}, 64'(f), 64'(exp_fl));
    chk({tag, " in_ready busy"}, 64'(ir_any), 64'd0);
    @(posedge clk); #1;
    sample(w, ov, ir, r, f);
    chk({tag, " drop"}, {62'd0, ov, ir}, 64'b01);
  endtask

  task automatic rst_mid_mul(input int w, input string tag);
    logic ov, ir;
    logic [63:0] r;
    logic [3:0] f;
    int seen;
    drive(w, 1'b1, 64'd3, 64'd5, OP_MUL);
    @(posedge clk); #1;
    drive(w, 1'b0, 64'd0, 64'd0, 4'h0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sample(w, ov, ir, r, f);
    chk({tag, " rst outputs"}, {r[31:0], 26'd0, ov, ir, f}, 64'd0);
    @(posedge clk); #2;
    sample(w, ov, ir, r, f);
    chk({tag, " rst in_ready held"}, 64'(ir), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sample(w, ov, ir, r, f);
    chk({tag, " in_ready after release"}, 64'(ir), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      sample(w, ov, ir, r, f);
      if (ov) seen++;
    end
    chk({tag, " no out_valid"}, 64'(seen), 64'd0);
  endtask

  initial begin
    int widths[3] = '{8, 16, 32};
    logic ov, ir;
    logic [63:0] r;
    logic [3:0] f;
    int late;

    rst_n = 1'b0;
    foreach (widths[i]) begin
      drive(widths[i], 1'b0, 64'd0, 64'd0, 4'h0);
      set_ordy(widths[i], 1'b1);
    end
    #12;
    foreach (widths[i]) begin
      sample(widths[i], ov, ir, r, f);
      chk($sformatf("w%0d reset state", widths[i]), {r[31:0], 26'd0, ov, ir, f}, 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sample(16, ov, ir, r, f);
    chk("w16 in_ready before edge", 64'(ir), 64'd0);
    @(posedge clk); #1;
    foreach (widths[i]) begin
      sample(widths[i], ov, ir, r, f);
      chk($sformatf("w%0d in_ready after reset", widths[i]), 64'(ir), 64'd1);
    end

    // WIDTH = 16
    run_op(16, "w16 add wrap",   64'hFFFF, 64'h0001, OP_ADD,  1,  64'h0000, 4'b0110);
    run_op(16, "w16 add ovf",    64'h7FFF, 64'h0001, OP_ADD,  1,  64'h8000, 4'b1001);
    run_op(16, "w16 sub ovf",    64'h8000, 64'h0001, OP_SUB,  1,  64'h7FFF, 4'b0001);
    run_op(16, "w16 sub borrow", 64'h0003, 64'h0005, OP_SUB,  1,  64'hFFFE, 4'b1010);
    run_op(16, "w16 rsub",       64'h0005, 64'h0003, OP_RSUB, 1,  64'hFFFE, 4'b1010);
    run_op(16, "w16 inc wrap",   64'hFFFF, 64'h1234, OP_INC,  1,  64'h0000, 4'b0110);
    run_op(16, "w16 dec wrap",   64'h0000, 64'h1234, OP_DEC,  1,  64'hFFFF, 4'b1010);
    run_op(16, "w16 mul carry",  64'h0100, 64'h0100, OP_MUL,  17, 64'h0000, 4'b0110);
    run_op(16, "w16 mul small",  64'h0003, 64'h0005, OP_MUL,  17, 64'h000F, 4'b0000);
    run_op(16, "w16 nota",       64'h1234, 64'h0000, OP_NOTA, 1,  64'hEDCB, 4'b1000);
    run_op(16, "w16 notb",       64'h0000, 64'h00FF, OP_NOTB, 1,  64'hFF00, 4'b1000);
    run_op(16, "w16 or",         64'h00F0, 64'h0F00, OP_OR,   1,  64'h0FF0, 4'b0000);
    run_op(16, "w16 nor",        64'h0000, 64'h0000, OP_NOR,  1,  64'hFFFF, 4'b1000);
    run_op(16, "w16 xnor",       64'hF0F0, 64'h0F0F, OP_XNOR, 1,  64'h0000, 4'b0100);
    run_op(16, "w16 and",        64'hF0F0, 64'h3C3C, OP_AND,  1,  64'h3030, 4'b0000);
    run_op(16, "w16 nand",       64'hFFFF, 64'hFFFF, OP_NAND, 1,  64'h0000, 4'b0100);
    run_op(16, "w16 shl 16",     64'h0001, 64'h0010, OP_SHL,  1,  64'h0000, 4'b0100);
    run_op(16, "w16 shr 15",     64'h8000, 64'h000F, OP_SHR,  1,  64'h0001, 4'b0000);
    run_op(16, "w16 shl 3",      64'h0001, 64'h0003, OP_SHL,  1,  64'h0008, 4'b0000);
    run_op(16, "w16 shr 256",    64'hFFFF, 64'h0100, OP_SHR,  1,  64'h0000, 4'b0100);

    // Backpressure: result held, new requests ignored while DONE.
    set_ordy(16, 1'b0);
    drive(16, 1'b1, 64'h00FF, 64'h0F0F, OP_XOR);
    @(posedge clk); #1;
    drive(16, 1'b1, 64'h0001, 64'h0001, OP_ADD);
    sample(16, ov, ir, r, f);
    chk("w16 bp first", {r[15:0], 42'd0, ov, ir, f}, {16'h0FF0, 42'd0, 1'b1, 1'b0, 4'b0000});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      sample(16, ov, ir, r, f);
      chk($sformatf("w16 bp hold %0d", i), {r[15:0], 42'd0, ov, ir, f},
          {16'h0FF0, 42'd0, 1'b1, 1'b0, 4'b0000});
    end
    set_ordy(16, 1'b1);
    drive(16, 1'b0, 64'd0, 64'd0, 4'h0);
    @(posedge clk); #1;
    sample(16, ov, ir, r, f);
    chk("w16 bp release", {62'd0, ov, ir}, 64'b01);
    run_op(16, "w16 after bp", 64'h0009, 64'h0002, OP_SUB, 1, 64'h0007, 4'b0000);
    late = 0;
    repeat (4) begin
      @(posedge clk); #1;
      sample(16, ov, ir, r, f);
      if (ov) late++;
    end
    chk("w16 no duplicate", 64'(late), 64'd0);

    // WIDTH = 8
    run_op(8, "w8 add wrap",  64'hFF, 64'h01, OP_ADD, 1, 64'h00, 4'b0110);
    run_op(8, "w8 sub ovf",   64'h80, 64'h01, OP_SUB, 1, 64'h7F, 4'b0001);
    run_op(8, "w8 dec wrap",  64'h00, 64'h00, OP_DEC, 1, 64'hFF, 4'b1010);
    run_op(8, "w8 mul carry", 64'h10, 64'h10, OP_MUL, 9, 64'h00, 4'b0110);
    run_op(8, "w8 mul neg",   64'h0B, 64'h0D, OP_MUL, 9, 64'h8F, 4'b1000);
    run_op(8, "w8 shl 8",     64'h01, 64'h08, OP_SHL, 1, 64'h00, 4'b0100);
    run_op(8, "w8 shr 7",     64'h80, 64'h07, OP_SHR, 1, 64'h01, 4'b0000);

    // WIDTH = 32
    run_op(32, "w32 add wrap",  64'hFFFF_FFFF, 64'h1,         OP_ADD, 1,  64'h0,          4'b0110);
    run_op(32, "w32 sub ovf",   64'h8000_0000, 64'h1,         OP_SUB, 1,  64'h7FFF_FFFF,  4'b0001);
    run_op(32, "w32 mul carry", 64'h0001_0000, 64'h0001_0000, OP_MUL, 33, 64'h0,          4'b0110);
    run_op(32, "w32 mul small", 64'h0000_1234, 64'h0000_0010, OP_MUL, 33, 64'h0001_2340,  4'b0000);
    run_op(32, "w32 shl 32",    64'h1,         64'd32,        OP_SHL, 1,  64'h0,          4'b0100);
    run_op(32, "w32 shr 31",    64'h8000_0000, 64'd31,        OP_SHR, 1,  64'h1,          4'b0000);
    run_op(32, "w32 shl 31",    64'h1,         64'd31,        OP_SHL, 1,  64'h8000_0000,  4'b1000);

    // Reset during a multiply abandons it.
    rst_mid_mul(16, "w16 mid-mul reset");
    rst_mid_mul(8,  "w8 mid-mul reset");
    rst_mid_mul(32, "w32 mid-mul reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
